// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes and execute-unit state encoding
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response handshake bundle; master = producer/consumer side, slave = execute unit
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  modport master (output in_valid, alu_control, src_a, src_b, out_ready,
                  input in_ready, out_valid, result, zero, illegal);
  modport slave (input in_valid, alu_control, src_a, src_b, out_ready,
                 output in_ready, out_valid, result, zero, illegal);
endinterface

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational ADD/SUB/AND/OR/SLT datapath (op, a, b -> y); other codes give 0
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic lt;
  assign lt = $signed(a) < $signed(b);
  always_comb
    y = op == ALU_ADD ? a + b :
        op == ALU_SUB ? a - b :
        op == ALU_AND ? a & b :
        op == ALU_OR  ? a | b :
        op == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt} : '0;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU execute stage (clk, rst async high, bus slave); ALU_EXEC_SHIFT_EN adds iterative shifts
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);
  state_t           state;
  logic [WIDTH-1:0] res;
  logic             ill;
  logic [WIDTH-1:0] core_y;
  logic             accept;
  logic             is_shift;
  assign bus.in_ready  = state == ST_IDLE || (state == ST_DONE && bus.out_ready);
  assign bus.out_valid = state == ST_DONE;
  assign bus.result    = res;
  assign bus.zero      = res == '0;
  assign bus.illegal   = ill;
  assign accept        = bus.in_valid && bus.in_ready;
  assign is_shift      = bus.alu_control == ALU_SLL || bus.alu_control == ALU_SRL ||
                         bus.alu_control == ALU_SRA;
  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op(bus.alu_control),
    .a (bus.src_a),
    .b (bus.src_b),
    .y (core_y)
  );
`ifdef ALU_EXEC_SHIFT_EN
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    shamt;
  logic [2:0]       op;
  logic [WIDTH-1:0] shifted;
  assign shamt   = bus.src_b[SW-1:0];
  assign shifted = op == ALU_SLL ? res << 1 : {op == ALU_SRA && res[WIDTH-1], res[WIDTH-1:1]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      res   <= '0;
      ill   <= 1'b0;
      cnt   <= '0;
      op    <= ALU_ADD;
    end else if (accept) begin
      op  <= bus.alu_control;
      ill <= 1'b0;
      if (is_shift) begin
        res   <= bus.src_a;
        cnt   <= shamt;
        state <= shamt == '0 ? ST_DONE : ST_SHIFT;
      end else begin
        res   <= core_y;
        state <= ST_DONE;
      end
    end else if (state == ST_SHIFT) begin
      res <= shifted;
      cnt <= cnt - 1'b1;
      if (cnt == SW'(1)) state <= ST_DONE;
    end else if (state == ST_DONE && bus.out_ready)
      state <= ST_IDLE;
`else
  // Unsupported shift codes fall through the core as 0 and are flagged illegal.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      res   <= '0;
      ill   <= 1'b0;
    end else if (accept) begin
      res   <= core_y;
      ill   <= is_shift;
      state <= ST_DONE;
    end else if (state == ST_DONE && bus.out_ready)
      state <= ST_IDLE;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized self-checking bench for alu_exec_unit against a behavioural model
module tb_alu_exec_unit;
  logic clk = 0;
  logic rst = 1;
  int n_tests = 0;
  int n_fail = 0;
  alu_exec_unit_if #(.WIDTH(32)) bus ();
  alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit shift_op(input logic [2:0] op);
    return op == 3'b100 || op == 3'b110 || op == 3'b111;
  endfunction
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_SHIFT_EN
      3'b100: return a << sh;
      3'b110: return a >> sh;
      default: return 32'($signed(a) >>> sh);
`else
      default: return 32'd0;
`endif
    endcase
  endfunction
  function automatic logic ref_ill(input logic [2:0] op);
`ifdef ALU_EXEC_SHIFT_EN
    return 1'b0;
`else
    return shift_op(op);
`endif
  endfunction
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_EXEC_SHIFT_EN
    return shift_op(op) ? 1 + int'(b % 32) : 1;
`else
    return 1;
`endif
  endfunction
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    int lat;
    logic [31:0] er;
    er = ref_res(op, a, b);
    @(negedge clk);
    bus.in_valid = 1;
    bus.alu_control = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.out_ready = 1;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("lat op%0d", op), 32'(lat), 32'(ref_lat(op, b)));
    check($sformatf("res op%0d a=%h b=%h", op, a, b), bus.result, er);
    check("zero", 32'(bus.zero), 32'(er == 0));
    check("illegal", 32'(bus.illegal), 32'(ref_ill(op)));
  endtask
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bus.in_valid = 0;
    bus.alu_control = 0;
    bus.src_a = 0;
    bus.src_b = 0;
    bus.out_ready = 1;
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(bus.out_valid), 0);
    check("rst result", bus.result, 0);
    check("rst zero", 32'(bus.zero), 1);
    check("rst illegal", 32'(bus.illegal), 0);
    check("rst in_ready", 32'(bus.in_ready), 1);
    rst = 0;
    run_op(3'b000, 32'h7FFF_FFFF, 32'd1);
    run_op(3'b001, 32'd5, 32'd5);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1);
    run_op(3'b101, 32'd1, 32'hFFFF_FFFF);
    run_op(3'b111, 32'h8000_0000, 32'd4);
    run_op(3'b100, 32'd1, 32'd0);
    run_op(3'b110, 32'hDEAD_BEEF, 32'd31);
    @(negedge clk);
    bus.in_valid = 1;
    bus.alu_control = 3'b010;
    bus.src_a = 32'hF0F0;
    bus.src_b = 32'hFF00;
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    check("b2b and", bus.result, 32'hF000);
    check("b2b in_ready", 32'(bus.in_ready), 1);
    bus.alu_control = 3'b011;
    bus.src_b = 32'h0F0F;
    @(posedge clk);
    #1;
    check("b2b or", bus.result, 32'hFFFF);
    check("b2b valid", 32'(bus.out_valid), 1);
    bus.out_ready = 0;
    bus.alu_control = 3'b000;
    bus.src_a = 32'd1;
    bus.src_b = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold result", bus.result, 32'hFFFF);
      check("hold valid", 32'(bus.out_valid), 1);
      check("hold in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(negedge clk);
    check("drain valid", 32'(bus.out_valid), 0);
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = a;
      if (i % 7 == 0) a = 32'h8000_0000;
      run_op(3'($urandom_range(0, 7)), a, b);
    end
    @(negedge clk);
    bus.in_valid = 1;
    bus.alu_control = 3'b110;
    bus.src_a = 32'hFFFF_FFFF;
    bus.src_b = 32'd31;
    bus.out_ready = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 0);
    check("midrst in_ready", 32'(bus.in_ready), 1);
    check("midrst result", bus.result, 0);
    @(negedge clk);
    rst = 0;
    bus.out_ready = 1;
    run_op(3'b000, 32'd3, 32'd4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-side counterpart of the ALU decoder: accepts the 3-bit `alu_control` code plus two operands, performs the operation and returns a registered result with zero flag. Sits in the execute stage, between decode/register read and writeback/branch logic. Uses a valid/ready handshake on both sides. Single-cycle ops complete in one cycle; the optional shift ops run iteratively, one bit per cycle.

## Interface
- `WIDTH`, default 32: operand/result width; must be a power of two ≥ 8.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operation request valid.
- `in_ready` output 1: unit can accept a request this cycle.
- `alu_control` input 3: op code (000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT, 100 SLL, 110 SRL, 111 SRA).
- `src_a` input WIDTH: operand A.
- `src_b` input WIDTH: operand B; low log2(WIDTH) bits form the shift amount.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `result` output WIDTH: operation result.
- `zero` output 1: `result == 0`.
- `illegal` output 1: op code not supported in this build.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept when `in_valid && in_ready`; `alu_control`, `src_a`, `src_b` sampled at that edge only.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`): back-to-back single-cycle ops at one per cycle.
- ADD/SUB: modulo 2^WIDTH, carry/borrow discarded. AND/OR: bitwise. SLT: signed two's-complement compare, result 1 or 0 zero-extended.
- Single-cycle op accepted → result registered, next state DONE.
- Shift op accepted: result ← `src_a`, counter ← shamt. shamt == 0 → DONE directly; otherwise SHIFT.
- SHIFT: each cycle shift result by one (SLL left zero-fill, SRL right zero-fill, SRA right sign-fill), decrement counter; when counter reaches 1 on that cycle → DONE.
- DONE: `out_valid` = 1, `result`/`zero`/`illegal` held stable until `out_ready`. Handshake → IDLE, or load of the new request if `in_valid` in the same cycle.
- `illegal` is registered with the result; `zero` is derived from the registered result.

## Timing
- Reset (async assert, sync release): state IDLE, `out_valid` 0, `result` 0, `zero` 1, `illegal` 0, counter 0; `in_ready` 1 after reset.
- Latency accept→`out_valid`: 1 cycle for single-cycle ops and shamt 0; 1 + shamt cycles for shifts (max WIDTH).
- `in_ready` is 0 throughout SHIFT and in DONE without `out_ready`; `in_valid` is ignored then.
- Reset asserted mid-SHIFT or in DONE: operation and pending result dropped, state IDLE immediately.
- No combinational path from `in_valid` to `out_valid`; `in_ready` depends combinationally on `out_ready` only.

## Configuration
- `ALU_EXEC_SHIFT_EN` defined: SLL/SRL/SRA (100/110/111) and SHIFT state implemented; `illegal` always 0.
- Not defined: no SHIFT state or counter; codes 100/110/111 complete in 1 cycle with `result` 0, `zero` 1, `illegal` 1.

## Structure
- Shared package `alu_pkg`: op-code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA) and the state encoding. The decoder uses the same constants.
- One sub-module: `alu_comb_core`, purely combinational ADD/SUB/AND/OR/SLT datapath. The FSM, shift register and handshake stay in `alu_exec_unit`.

## Test plan
- Reset then ADD 0x7FFFFFFF + 1, `out_ready` = 1 → `out_valid` next cycle, result 0x80000000, zero 0; SUB 5 − 5 → result 0, zero 1.
- SLT −1 (0xFFFFFFFF) vs 1 → result 1; SLT 1 vs −1 → result 0.
- Back-to-back AND 0xF0F0 & 0xFF00 then OR 0xF0F0 | 0x0F0F, `out_ready` held 1 → results 0xF000 and 0xFFFF on consecutive cycles, `in_ready` never drops.
- `out_ready` held 0 for 3 cycles after OR result → `result`/`out_valid` stable, `in_ready` 0, a new `in_valid` is not accepted.
- With `ALU_EXEC_SHIFT_EN`: SRA 0x80000000 by 4 → `out_valid` 5 cycles after accept, result 0xF8000000. SLL 1 by 0 → 1-cycle latency, result 1.
- Without the macro: code 110 → 1-cycle result 0, `illegal` 1. Reset pulsed during a 31-cycle shift → `out_valid` 0 and `in_ready` 1 after reset.
